// File: rtl/timekeeper_alarm.sv
// Binary HH:MM:SS timekeeper with ALARM_CH alarm channels and a registered sounder FSM.
// Define HOURLY_CHIME_EN to add a one-second chime on every tick-driven xx:00:00.
module timekeeper_alarm #(
   parameter int ALARM_CH  = 2,
   parameter int HOUR_MOD  = 24,
   parameter int BEEP_SECS = 10,
   localparam int CW = (ALARM_CH > 1) ? $clog2(ALARM_CH) : 1
) (
   input  logic                clk_sys,
   input  logic                clear,
   input  logic                tick_sec,
   input  logic                adjust_sec,
   input  logic                adjust_min,
   input  logic                adjust_hour,
   input  logic                keep,
   input  logic                alarm_wr,
   input  logic [CW-1:0]       alarm_sel,
   input  logic [5:0]          alarm_min,
   input  logic [4:0]          alarm_hour,
   input  logic                alarm_on,
   input  logic                alarm_ack,
   output logic [5:0]          sec,
   output logic [5:0]          min,
   output logic [4:0]          hour,
   output logic                clk_day,
   output logic [ALARM_CH-1:0] alarm_hit,
   output logic                beep,
   output logic [1:0]          sounder_state
);

   // sounder_state encoding: 0 IDLE, 1 RING, 2 MUTE, 3 CHIME
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RING  = 2'd1;
   localparam logic [1:0] ST_MUTE  = 2'd2;
`ifdef HOURLY_CHIME_EN
   localparam logic [1:0] ST_CHIME = 2'd3;
`endif
   localparam logic [5:0] SEC_MAX   = 6'd59;
   localparam logic [5:0] MIN_MAX   = 6'd59;
   localparam logic [4:0] HOUR_MAX  = 5'(HOUR_MOD - 1);
   localparam logic [5:0] RING_LAST = 6'(BEEP_SECS - 1);

   logic [5:0] sec_q, sec_d, min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic       day_q, day_d;
   logic       evt_q, evt_d;
   logic       adj_any;

   logic [ALARM_CH-1:0][5:0] al_min_q, al_min_d;
   logic [ALARM_CH-1:0][4:0] al_hour_q, al_hour_d;
   logic [ALARM_CH-1:0]      al_on_q, al_on_d;
   logic [ALARM_CH-1:0]      hit_q, hit_d;
   logic [ALARM_CH-1:0]      match;
   logic                     wr_ok;
   logic                     new_hit;

   logic [1:0] state_q, state_d;
   logic [5:0] ring_q, ring_d;
   logic       beep_q, beep_d;
`ifdef HOURLY_CHIME_EN
   logic [1:0] prior_q, prior_d;
   logic       chime_go;
`endif

   // Any adjust pulse swallows a coincident tick; adjusts never carry.
   always_comb begin
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      day_d   = 1'b0;
      evt_d   = 1'b0;
      adj_any = adjust_sec | adjust_min | adjust_hour;
      if (adj_any) begin
         if (adjust_sec)  sec_d  = '0;
         if (adjust_min)  min_d  = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
         if (adjust_hour) hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
      end else if (tick_sec && !keep) begin
         if (sec_q == SEC_MAX) begin
            sec_d = '0;
            evt_d = 1'b1;
            if (min_q == MIN_MAX) begin
               min_d = '0;
               if (hour_q == HOUR_MAX) begin
                  hour_d = '0;
                  day_d  = 1'b1;
               end else begin
                  hour_d = hour_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   // evt_q marks the cycle right after a tick-driven arrival at sec=0.
   always_comb begin
      wr_ok = alarm_wr && (int'(alarm_sel) < ALARM_CH) && (alarm_min <= 6'd59)
              && (int'(alarm_hour) < HOUR_MOD);
      for (int c = 0; c < ALARM_CH; c++) begin
         match[c] = evt_q && al_on_q[c] && (al_min_q[c] == min_q) && (al_hour_q[c] == hour_q);
      end
      new_hit = |match;
`ifdef HOURLY_CHIME_EN
      chime_go = evt_q && (min_q == '0);
`endif
   end

   always_comb begin
      al_min_d  = al_min_q;
      al_hour_d = al_hour_q;
      al_on_d   = al_on_q;
      hit_d     = alarm_ack ? '0 : hit_q;
      for (int c = 0; c < ALARM_CH; c++) begin
         if (wr_ok && (alarm_sel == CW'(c))) begin
            al_min_d[c]  = alarm_min;
            al_hour_d[c] = alarm_hour;
            al_on_d[c]   = alarm_on;
            hit_d[c]     = 1'b0;
         end
      end
      hit_d = hit_d | match;
   end

   always_comb begin
      state_d = state_q;
      ring_d  = ring_q;
`ifdef HOURLY_CHIME_EN
      prior_d = prior_q;
`endif
      if (new_hit) begin
         state_d = ST_RING;
         ring_d  = '0;
      end else begin
         case (state_q)
            ST_RING: begin
               if (alarm_ack) begin
                  state_d = ST_IDLE;
                  ring_d  = '0;
               end else if (tick_sec) begin
                  if (ring_q == RING_LAST) begin
                     state_d = ST_MUTE;
                     ring_d  = '0;
                  end else begin
                     ring_d = ring_q + 6'd1;
                  end
               end
            end
            ST_MUTE: begin
`ifdef HOURLY_CHIME_EN
               if (chime_go) begin
                  state_d = ST_CHIME;
                  prior_d = alarm_ack ? ST_IDLE : ST_MUTE;
               end else
`endif
               if (alarm_ack) state_d = ST_IDLE;
            end
`ifdef HOURLY_CHIME_EN
            ST_IDLE: begin
               if (chime_go) begin
                  state_d = ST_CHIME;
                  prior_d = ST_IDLE;
               end
            end
            // Chime lasts until the next tick, then resumes where it came from.
            ST_CHIME: begin
               if (alarm_ack) prior_d = ST_IDLE;
               if (tick_sec)  state_d = alarm_ack ? ST_IDLE : prior_q;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
`ifdef HOURLY_CHIME_EN
      beep_d = (state_d == ST_RING) || (state_d == ST_CHIME);
`else
      beep_d = (state_d == ST_RING);
`endif
   end

   always_ff @(posedge clk_sys or posedge clear) begin
      if (clear) begin
         sec_q     <= '0;
         min_q     <= '0;
         hour_q    <= '0;
         day_q     <= 1'b0;
         evt_q     <= 1'b0;
         al_min_q  <= '0;
         al_hour_q <= '0;
         al_on_q   <= '0;
         hit_q     <= '0;
         state_q   <= ST_IDLE;
         ring_q    <= '0;
         beep_q    <= 1'b0;
`ifdef HOURLY_CHIME_EN
         prior_q   <= ST_IDLE;
`endif
      end else begin
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         day_q     <= day_d;
         evt_q     <= evt_d;
         al_min_q  <= al_min_d;
         al_hour_q <= al_hour_d;
         al_on_q   <= al_on_d;
         hit_q     <= hit_d;
         state_q   <= state_d;
         ring_q    <= ring_d;
         beep_q    <= beep_d;
`ifdef HOURLY_CHIME_EN
         prior_q   <= prior_d;
`endif
      end
   end

   assign sec           = sec_q;
   assign min           = min_q;
   assign hour          = hour_q;
   assign clk_day       = day_q;
   assign alarm_hit     = hit_q;
   assign beep          = beep_q;
   assign sounder_state = state_q;

endmodule

// File: tb/tb_timekeeper_alarm.sv
// Bench for timekeeper_alarm: directed scenarios plus randomized traffic checked
// against a seconds-of-day reference model; a 12-hour, 3-channel copy covers the 12 h wrap.
module tb_timekeeper_alarm;

   localparam int BEEP = 10;
   localparam logic [1:0] M_IDLE  = 2'd0;
   localparam logic [1:0] M_RING  = 2'd1;
   localparam logic [1:0] M_MUTE  = 2'd2;
   localparam logic [1:0] M_CHIME = 2'd3;

   logic       clk_sys = 1'b0;
   logic       clear = 1'b1;
   logic       tick_sec = 1'b0, adjust_sec = 1'b0, adjust_min = 1'b0, adjust_hour = 1'b0;
   logic       keep = 1'b0, alarm_wr = 1'b0, alarm_on = 1'b0, alarm_ack = 1'b0;
   logic [0:0] alarm_sel = '0;
   logic [5:0] alarm_min = '0;
   logic [4:0] alarm_hour = '0;
   logic [5:0] sec, min;
   logic [4:0] hour;
   logic       clk_day, beep;
   logic [1:0] alarm_hit, sounder_state;

   logic       wr12 = 1'b0;
   logic [1:0] sel12 = '0;
   logic [5:0] sec12, min12;
   logic [4:0] hour12;
   logic       day12, beep12;
   logic [2:0] hit12;
   logic [1:0] state12;

   int n_checks = 0;
   int n_err = 0;

   // reference model: time kept as seconds of the day
   int         m_t, m_left;
   bit         m_day, m_evt;
   int         m_amin[2], m_ahour[2];
   bit         m_aon[2];
   logic [1:0] m_hit, m_mode, m_resume;
   logic [22:0] exp_q[$];

   timekeeper_alarm dut (
      .clk_sys(clk_sys), .clear(clear), .tick_sec(tick_sec), .adjust_sec(adjust_sec),
      .adjust_min(adjust_min), .adjust_hour(adjust_hour), .keep(keep), .alarm_wr(alarm_wr),
      .alarm_sel(alarm_sel), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
      .alarm_on(alarm_on), .alarm_ack(alarm_ack), .sec(sec), .min(min), .hour(hour),
      .clk_day(clk_day), .alarm_hit(alarm_hit), .beep(beep), .sounder_state(sounder_state));

   timekeeper_alarm #(.ALARM_CH(3), .HOUR_MOD(12)) dut12 (
      .clk_sys(clk_sys), .clear(clear), .tick_sec(tick_sec), .adjust_sec(adjust_sec),
      .adjust_min(adjust_min), .adjust_hour(adjust_hour), .keep(keep), .alarm_wr(wr12),
      .alarm_sel(sel12), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
      .alarm_on(alarm_on), .alarm_ack(alarm_ack), .sec(sec12), .min(min12), .hour(hour12),
      .clk_day(day12), .alarm_hit(hit12), .beep(beep12), .sounder_state(state12));

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_left = 0; m_day = 0; m_evt = 0; m_hit = '0;
      m_mode = M_IDLE; m_resume = M_IDLE;
      for (int c = 0; c < 2; c++) begin
         m_amin[c] = 0; m_ahour[c] = 0; m_aon[c] = 0;
      end
   endtask

   task automatic model_step();
      int cs, cm, ch;
      logic [1:0] fresh;
      bit chime;
      if (clear) begin
         model_reset();
         return;
      end
      cs = m_t % 60; cm = (m_t / 60) % 60; ch = m_t / 3600;
      fresh = '0;
      for (int c = 0; c < 2; c++)
         if (m_evt && m_aon[c] && m_amin[c] == cm && m_ahour[c] == ch) fresh[c] = 1'b1;
      chime = m_evt && (cm == 0);
      if (fresh != 0) begin
         m_mode = M_RING; m_left = BEEP;
      end else if (m_mode == M_RING) begin
         if (alarm_ack) m_mode = M_IDLE;
         else if (tick_sec) begin
            m_left--;
            if (m_left == 0) m_mode = M_MUTE;
         end
`ifdef HOURLY_CHIME_EN
      end else if (m_mode == M_CHIME) begin
         if (alarm_ack) m_resume = M_IDLE;
         if (tick_sec) m_mode = m_resume;
      end else if (chime) begin
         m_resume = alarm_ack ? M_IDLE : m_mode;
         m_mode = M_CHIME;
`endif
      end else if (alarm_ack) begin
         m_mode = M_IDLE;
      end
      if (alarm_ack) m_hit = '0;
      if (alarm_wr && alarm_min <= 59 && alarm_hour < 24) begin
         m_amin[alarm_sel] = alarm_min; m_ahour[alarm_sel] = alarm_hour;
         m_aon[alarm_sel] = alarm_on; m_hit[alarm_sel] = 1'b0;
      end
      m_hit = m_hit | fresh;
      m_day = 0; m_evt = 0;
      if (adjust_sec || adjust_min || adjust_hour) begin
         if (adjust_sec)  cs = 0;
         if (adjust_min)  cm = (cm + 1) % 60;
         if (adjust_hour) ch = (ch + 1) % 24;
         m_t = ch * 3600 + cm * 60 + cs;
      end else if (tick_sec && !keep) begin
         m_t = (m_t + 1) % 86400;
         m_evt = (m_t % 60 == 0);
         m_day = (m_t == 0);
      end
   endtask

   task automatic compare_all();
      logic [22:0] e;
      e = exp_q.pop_front();
      check("sec", sec, e[22:17]);
      check("min", min, e[16:11]);
      check("hour", hour, e[10:6]);
      check("clk_day", clk_day, e[5]);
      check("alarm_hit", alarm_hit, e[4:3]);
      check("beep", beep, e[2]);
      check("state", sounder_state, e[1:0]);
   endtask

   task automatic cycle();
      logic bp;
      @(posedge clk_sys);
      model_step();
      bp = (m_mode == M_RING) || (m_mode == M_CHIME);
      exp_q.push_back({6'(m_t % 60), 6'((m_t / 60) % 60), 5'(m_t / 3600), m_day, m_hit, bp, m_mode});
      #1;
      compare_all();
      tick_sec = 0; adjust_sec = 0; adjust_min = 0; adjust_hour = 0;
      alarm_wr = 0; wr12 = 0; alarm_ack = 0;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      clear = 1; cycle(); clear = 0;
      for (int i = 0; i < h; i++) begin adjust_hour = 1; cycle(); end
      for (int i = 0; i < m; i++) begin adjust_min = 1; cycle(); end
      for (int i = 0; i < s; i++) begin tick_sec = 1; cycle(); end
   endtask

   task automatic write_alarm(input int ch, input int m, input int h, input bit on);
      alarm_wr = 1; alarm_sel = 1'(ch); alarm_min = 6'(m); alarm_hour = 5'(h); alarm_on = on;
      cycle();
   endtask

   initial begin
      model_reset();
      // reset state
      cycle(); cycle();
      clear = 0;
      cycle();

      // 23:59:59 -> 00:00:00 with one clk_day pulse
      set_time(23, 59, 59);
      tick_sec = 1; cycle();
      check("wrap24_time", {sec, min, hour}, 17'd0);
      check("wrap24_day", clk_day, 1'b1);
      cycle();
      check("wrap24_day_off", clk_day, 1'b0);

      // 12-hour copy: 11:59:59 -> 00:00:00
      set_time(11, 59, 59);
      check("h12_pre_hour", hour12, 5'd11);
      tick_sec = 1; cycle();
      check("h12_time", {sec12, min12, hour12}, 17'd0);
      check("h12_day", day12, 1'b1);
      check("h24_hour12", hour, 5'd12);
      cycle();
      check("h12_day_off", day12, 1'b0);

      // adjust_min with coincident tick at 05:59:30
      set_time(5, 59, 30);
      adjust_min = 1; tick_sec = 1; cycle();
      check("adj_tick_min", min, 6'd0);
      check("adj_tick_hour", hour, 5'd5);
      check("adj_tick_sec", sec, 6'd30);
      keep = 1;
      for (int i = 0; i < 3; i++) begin tick_sec = 1; cycle(); end
      keep = 0; adjust_sec = 1; cycle();
      keep = 1; adjust_sec = 1; adjust_min = 1; adjust_hour = 1; cycle();
      keep = 0;

      // ch1 alarm 07:30 rings for exactly 10 ticks, then mutes; ack -> idle
      set_time(7, 29, 59);
      write_alarm(1, 30, 7, 1);
      tick_sec = 1; cycle();
      cycle();
      check("a20_hit", alarm_hit, 2'b10);
      check("a20_beep_on", beep, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         tick_sec = 1; cycle(); cycle();
         check($sformatf("a20_beep_t%0d", i), beep, (i < 10) ? 1'b1 : 1'b0);
      end
      check("a20_mute", sounder_state, M_MUTE);
      alarm_ack = 1; cycle();
      check("a20_ack_hit", alarm_hit, 2'b00);
      check("a20_ack_idle", sounder_state, M_IDLE);

      // rejected writes leave ch0 intact; invalid channel on the 3-channel copy
      write_alarm(0, 31, 7, 1);
      write_alarm(0, 60, 7, 0);
      write_alarm(0, 31, 24, 0);
      wr12 = 1; sel12 = 2'd3; alarm_min = 6'd31; alarm_hour = 5'd7; alarm_on = 1; cycle();
      for (int i = 0; i < 50; i++) begin tick_sec = 1; cycle(); end
      cycle();
      check("a21_hit_kept", alarm_hit, 2'b01);
      check("a21_sel3_ignored", hit12, 3'b000);
      alarm_ack = 1; cycle();
      write_alarm(1, 31, 8, 1);
      adjust_hour = 1; cycle();
      adjust_sec = 1; cycle();
      cycle(); cycle();
      check("a21_adjust_nohit", alarm_hit, 2'b00);

      // asynchronous clear in the middle of a ring
      set_time(9, 14, 59);
      write_alarm(0, 15, 9, 1);
      tick_sec = 1; cycle(); cycle();
      check("rst_ringing", beep, 1'b1);
      #2 clear = 1;
      #1;
      check("rst_beep", beep, 1'b0);
      check("rst_time", {sec, min, hour}, 17'd0);
      check("rst_hit", alarm_hit, 2'b00);
      check("rst_state", sounder_state, M_IDLE);
      model_reset();
      cycle();
      clear = 0;
      cycle();

      // hourly chime at 08:59:59 -> 09:00:00
      set_time(8, 59, 59);
      tick_sec = 1; cycle(); cycle();
`ifdef HOURLY_CHIME_EN
      check("chime_on", beep, 1'b1);
`else
      check("chime_absent", beep, 1'b0);
`endif
      cycle(); cycle();
      tick_sec = 1; cycle();
      check("chime_off", beep, 1'b0);

      // randomized traffic
      set_time(3, 57, 30);
      for (int i = 0; i < 3000; i++) begin
         tick_sec    = ($urandom_range(0, 1) == 1);
         keep        = ($urandom_range(0, 9) == 0);
         adjust_sec  = ($urandom_range(0, 59) == 0);
         adjust_min  = ($urandom_range(0, 59) == 0);
         adjust_hour = ($urandom_range(0, 59) == 0);
         alarm_ack   = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 24) == 0) begin
            alarm_wr   = 1;
            alarm_sel  = 1'($urandom_range(0, 1));
            alarm_min  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(60, 63))
                                                     : 6'(((m_t / 60) % 60 + $urandom_range(0, 2)) % 60);
            alarm_hour = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'(m_t / 3600);
            alarm_on   = ($urandom_range(0, 3) != 0);
         end
         cycle();
      end
      keep = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
